// File: rtl/weight_load_sequencer.sv
// Round-robin weight-load instruction sequencer: pops one job from NUM_CH show-ahead FIFOs,
// splits it into bounded read bursts and pulses job_done. Define WLS_PERF_CNT_EN for stall_cnt.
module weight_load_sequencer #(
   parameter  int NUM_CH    = 2,
   parameter  int WADDR_W   = 16,
   parameter  int MADDR_W   = 32,
   parameter  int SEQ_W     = 8,
   parameter  int BURST_LEN = 8,
   parameter  int MAX_OUT   = 4,
   localparam int LEN_W     = $clog2(BURST_LEN) + 1,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W     = $clog2(MAX_OUT + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_CH-1:0]         fifo_empty,
   output logic [NUM_CH-1:0]         fifo_en,
   input  logic [NUM_CH*WADDR_W-1:0] inst_waddr,
   input  logic [NUM_CH*WADDR_W-1:0] inst_wend,
   input  logic [NUM_CH*MADDR_W-1:0] inst_wpos,
   input  logic [NUM_CH*SEQ_W-1:0]   inst_seq,
   output logic                      req_valid,
   input  logic                      req_ready,
   output logic [MADDR_W-1:0]        req_addr,
   output logic [LEN_W-1:0]          req_len,
   output logic [SEQ_W-1:0]          req_seq,
   output logic [CH_W-1:0]           req_ch,
   input  logic                      rsp_done,
   output logic                      reading,
   output logic                      job_done,
`ifdef WLS_PERF_CNT_EN
   output logic [31:0]               stall_cnt,
`endif
   output logic [SEQ_W-1:0]          job_seq
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t              state;
   logic [CH_W-1:0]     rr_ptr;
   logic [WADDR_W-1:0]  next_q, end_q;
   logic [MADDR_W-1:0]  pos_q;
   logic [SEQ_W-1:0]    seq_q;
   logic [CH_W-1:0]     ch_q;
   logic [CNT_W-1:0]    out_cnt, cnt_next;

   logic                grant_found, grant_valid;
   logic [CH_W-1:0]     grant_idx;
   logic [WADDR_W-1:0]  g_waddr, g_wend;
   logic [MADDR_W-1:0]  g_wpos;
   logic [SEQ_W-1:0]    g_seq;

   logic [WADDR_W-1:0]  remain;
   logic                last_burst, hs, rsp_take;
   logic [LEN_W-1:0]    burst_len;

   // First non-empty channel at or after rr_ptr, wrapping.
   always_comb begin
      int c;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         c = int'(rr_ptr) + k;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!grant_found && !fifo_empty[c]) begin
            grant_found = 1'b1;
            grant_idx   = c[CH_W-1:0];
         end
      end
   end

   // Reset gates the grant so no FIFO is popped while the block is being cleared.
   assign grant_valid = !reset && (state == S_IDLE) && enable && grant_found;

   always_comb begin
      fifo_en = '0;
      if (grant_valid) fifo_en[grant_idx] = 1'b1;
   end

   assign g_waddr = inst_waddr[grant_idx*WADDR_W +: WADDR_W];
   assign g_wend  = inst_wend[grant_idx*WADDR_W +: WADDR_W];
   assign g_wpos  = inst_wpos[grant_idx*MADDR_W +: MADDR_W];
   assign g_seq   = inst_seq[grant_idx*SEQ_W +: SEQ_W];

   assign remain     = end_q - next_q;
   assign last_burst = remain <= WADDR_W'(BURST_LEN);
   assign burst_len  = last_burst ? remain[LEN_W-1:0] : LEN_W'(BURST_LEN);

   assign req_valid = (state == S_ISSUE) && (out_cnt < CNT_W'(MAX_OUT));
   assign hs        = req_valid && req_ready;
   assign rsp_take  = rsp_done && (out_cnt != '0);

   always_comb begin
      cnt_next = out_cnt;
      if (hs && !rsp_take)      cnt_next = out_cnt + 1'b1;
      else if (!hs && rsp_take) cnt_next = out_cnt - 1'b1;
   end

   assign req_addr = pos_q;
   assign req_len  = burst_len;
   assign req_seq  = seq_q;
   assign req_ch   = ch_q;
   assign job_seq  = seq_q;
   assign reading  = (state != S_IDLE);
   assign job_done = (state == S_DONE);

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (reset) begin
         state   <= S_IDLE;
         rr_ptr  <= '0;
         next_q  <= '0;
         end_q   <= '0;
         pos_q   <= '0;
         seq_q   <= '0;
         ch_q    <= '0;
         out_cnt <= '0;
      end else begin
         out_cnt <= cnt_next;
         case (state)
            S_IDLE: begin
               if (grant_valid) begin
                  next_q <= g_waddr;
                  end_q  <= g_wend;
                  pos_q  <= g_wpos;
                  seq_q  <= g_seq;
                  ch_q   <= grant_idx;
                  rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                  state  <= (g_waddr >= g_wend) ? S_DRAIN : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (hs) begin
                  next_q <= next_q + WADDR_W'(burst_len);
                  pos_q  <= pos_q + MADDR_W'(burst_len);
                  if (last_burst) state <= S_DRAIN;
               end
            end
            // Looking at the next count lets the pulse follow the final response by one cycle.
            S_DRAIN: if (cnt_next == '0) state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef WLS_PERF_CNT_EN
   logic stall_evt;
   assign stall_evt = (req_valid && !req_ready) ||
                      ((state == S_ISSUE) && (out_cnt == CNT_W'(MAX_OUT)));

   always_ff @(posedge clock) begin
      if (reset)                           stall_cnt <= '0;
      else if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed self-checking bench for weight_load_sequencer: single/empty jobs, round-robin,
// outstanding limit, backpressure and reset mid-job.
module tb_weight_load_sequencer;
   localparam int NUM_CH = 2;
   localparam int QD     = 12;
   localparam int LD     = 16;

   logic        clock = 1'b0;
   logic        reset, enable, req_ready, rsp_done;
   logic [1:0]  fifo_empty, fifo_en;
   logic [31:0] inst_waddr, inst_wend;
   logic [63:0] inst_wpos;
   logic [15:0] inst_seq;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic [7:0]  req_seq;
   logic [0:0]  req_ch;
   logic        reading, job_done;
   logic [7:0]  job_seq;
`ifdef WLS_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   weight_load_sequencer dut (
      .clock(clock), .reset(reset), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_en(fifo_en),
      .inst_waddr(inst_waddr), .inst_wend(inst_wend), .inst_wpos(inst_wpos), .inst_seq(inst_seq),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .req_seq(req_seq), .req_ch(req_ch), .rsp_done(rsp_done),
      .reading(reading), .job_done(job_done),
`ifdef WLS_PERF_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .job_seq(job_seq)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] waddr;
      logic [15:0] wend;
      logic [31:0] wpos;
      logic [7:0]  seq;
   } job_t;

   job_t jobs [NUM_CH][QD];
   int   nq [NUM_CH];
   int   hd [NUM_CH];

   int   tests_run = 0;
   int   tests_failed = 0;
   int   cyc = 0;
   logic auto_rsp;
   logic [1:0] rsp_pipe;

   logic [31:0] hs_addr [LD];
   logic [3:0]  hs_len  [LD];
   logic [7:0]  hs_seq  [LD];
   logic        hs_ch   [LD];
   int          hs_cyc  [LD];
   int          n_hs;
   logic [1:0]  pop_en  [LD];
   int          pop_cyc [LD];
   int          n_pop;
   logic [7:0]  jd_seq  [LD];
   int          jd_cyc  [LD];
   int          n_jd;
   logic        rd_log  [1024];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_heads();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (hd[ch] < nq[ch]) begin
            fifo_empty[ch]          = 1'b0;
            inst_waddr[ch*16 +: 16] = jobs[ch][hd[ch]].waddr;
            inst_wend[ch*16 +: 16]  = jobs[ch][hd[ch]].wend;
            inst_wpos[ch*32 +: 32]  = jobs[ch][hd[ch]].wpos;
            inst_seq[ch*8 +: 8]     = jobs[ch][hd[ch]].seq;
         end else begin
            fifo_empty[ch]          = 1'b1;
            inst_waddr[ch*16 +: 16] = '0;
            inst_wend[ch*16 +: 16]  = '0;
            inst_wpos[ch*32 +: 32]  = '0;
            inst_seq[ch*8 +: 8]     = '0;
         end
      end
   endtask

   task automatic push_job(input int ch, input logic [15:0] wa, input logic [15:0] we,
                           input logic [31:0] wp, input logic [7:0] sq);
      jobs[ch][nq[ch]].waddr = wa;
      jobs[ch][nq[ch]].wend  = we;
      jobs[ch][nq[ch]].wpos  = wp;
      jobs[ch][nq[ch]].seq   = sq;
      nq[ch]++;
      drive_heads();
   endtask

   task automatic clear_logs();
      n_hs  = 0;
      n_pop = 0;
      n_jd  = 0;
   endtask

   // One clock: sample and log outputs, advance the edge, update FIFO model and responder.
   task automatic cycle();
      logic       hs;
      logic [1:0] popped;
      #1;
      hs     = req_valid && req_ready;
      popped = fifo_en;
      if (hs) begin
         if (n_hs < LD) begin
            hs_addr[n_hs] = req_addr;
            hs_len[n_hs]  = req_len;
            hs_seq[n_hs]  = req_seq;
            hs_ch[n_hs]   = req_ch[0];
            hs_cyc[n_hs]  = cyc;
         end
         n_hs++;
      end
      if (popped != 2'b00) begin
         if (n_pop < LD) begin
            pop_en[n_pop]  = popped;
            pop_cyc[n_pop] = cyc;
         end
         n_pop++;
      end
      if (job_done) begin
         if (n_jd < LD) begin
            jd_seq[n_jd] = job_seq;
            jd_cyc[n_jd] = cyc;
         end
         n_jd++;
      end
      if (cyc < 1024) rd_log[cyc] = reading;
      @(posedge clock);
      #1;
      cyc++;
      for (int ch = 0; ch < NUM_CH; ch++) if (popped[ch]) hd[ch]++;
      drive_heads();
      rsp_pipe = {rsp_pipe[0], hs};
      rsp_done = auto_rsp && rsp_pipe[1];
      #2;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) cycle();
      reset = 1'b0;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_fifo_en"},   fifo_en,   0);
      check({pfx, "_req_valid"}, req_valid, 0);
      check({pfx, "_req_addr"},  req_addr,  0);
      check({pfx, "_req_len"},   req_len,   0);
      check({pfx, "_req_seq"},   req_seq,   0);
      check({pfx, "_req_ch"},    req_ch,    0);
      check({pfx, "_reading"},   reading,   0);
      check({pfx, "_job_done"},  job_done,  0);
      check({pfx, "_job_seq"},   job_seq,   0);
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      req_ready = 1'b1;
      rsp_done  = 1'b0;
      auto_rsp  = 1'b1;
      rsp_pipe  = 2'b00;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         nq[ch] = 0;
         hd[ch] = 0;
      end
      drive_heads();
      clear_logs();
      @(posedge clock);
      #3;
      do_reset(3);
      check_all_zero("reset");
`ifdef WLS_PERF_CNT_EN
      check("reset_stall_cnt", stall_cnt, 0);
`endif

      // Single job: 20 words from 0x100 -> bursts of 8, 8, 4.
      enable = 1'b1;
      clear_logs();
      push_job(0, 16'd0, 16'd20, 32'h100, 8'd5);
      repeat (12) cycle();
      check("single_pops", n_pop, 1);
      check("single_pop_en", pop_en[0], 2'b01);
      check("single_hs_cnt", n_hs, 3);
      check("single_hs0_addr", hs_addr[0], 32'h100);
      check("single_hs0_len", hs_len[0], 8);
      check("single_hs1_addr", hs_addr[1], 32'h108);
      check("single_hs1_len", hs_len[1], 8);
      check("single_hs2_addr", hs_addr[2], 32'h110);
      check("single_hs2_len", hs_len[2], 4);
      check("single_hs_seq", {hs_seq[0], hs_seq[1], hs_seq[2]}, {8'd5, 8'd5, 8'd5});
      check("single_first_req_lat", hs_cyc[0] - pop_cyc[0], 1);
      check("single_done_cnt", n_jd, 1);
      check("single_done_seq", jd_seq[0], 5);
      check("single_done_lat", jd_cyc[0] - pop_cyc[0], 6);
      check("single_reading_at_pop", rd_log[pop_cyc[0]], 0);
      check("single_reading_in_job", rd_log[pop_cyc[0] + 1], 1);
      check("single_reading_at_done", rd_log[jd_cyc[0]], 1);
      check("single_reading_after", rd_log[jd_cyc[0] + 1], 0);

      // Empty job: waddr == wend.
      clear_logs();
      push_job(0, 16'd7, 16'd7, 32'h200, 8'd9);
      repeat (8) cycle();
      check("empty_pops", n_pop, 1);
      check("empty_no_req", n_hs, 0);
      check("empty_done_cnt", n_jd, 1);
      check("empty_done_seq", jd_seq[0], 9);
      check("empty_done_lat", jd_cyc[0] - pop_cyc[0], 2);

      // Round-robin with rr_ptr freshly reset to 0.
      enable = 1'b0;
      do_reset(2);
      push_job(0, 16'd0, 16'd4, 32'h1000, 8'h10);
      push_job(1, 16'd0, 16'd4, 32'h2000, 8'h11);
      push_job(0, 16'd0, 16'd4, 32'h3000, 8'h12);
      push_job(1, 16'd0, 16'd4, 32'h4000, 8'h13);
      clear_logs();
      enable = 1'b1;
      repeat (30) cycle();
      check("rr_pops", n_pop, 4);
      check("rr_order", {pop_en[0], pop_en[1], pop_en[2], pop_en[3]}, {2'b01, 2'b10, 2'b01, 2'b10});
      check("rr_req_ch", {hs_ch[0], hs_ch[1], hs_ch[2], hs_ch[3]}, 4'b0101);
      check("rr_req_addr2", hs_addr[2], 32'h3000);
      check("rr_req_len", hs_len[1], 4);
      check("rr_done_seqs", {jd_seq[0], jd_seq[1], jd_seq[2], jd_seq[3]}, 32'h10111213);
      check("rr_regrant_gap", pop_cyc[1] - jd_cyc[0], 1);

      // Outstanding limit: 64 words, responses held back.
      auto_rsp = 1'b0;
      rsp_pipe = 2'b00;
      clear_logs();
      push_job(0, 16'd0, 16'd64, 32'h0, 8'h20);
      repeat (5) cycle();
      check("ol_4hs", n_hs, 4);
      check("ol_blocked", req_valid, 0);
      check("ol_reading", reading, 1);
      repeat (2) cycle();
      check("ol_hold_hs", n_hs, 4);
      check("ol_hold_valid", req_valid, 0);
      rsp_done = 1'b1;
      cycle();
      check("ol_resume", req_valid, 1);
      rsp_done = 1'b1;
      cycle();
      check("ol_simul_unchanged", req_valid, 1);
      cycle();
      check("ol_full_again", req_valid, 0);
      check("ol_hs_total", n_hs, 6);
      check("ol_hs4_addr", hs_addr[4], 32'h20);
      check("ol_hs5_addr", hs_addr[5], 32'h28);
      check("ol_no_done", n_jd, 0);

      // Backpressure from a clean reset.
      do_reset(2);
      auto_rsp  = 1'b1;
      rsp_pipe  = 2'b00;
      req_ready = 1'b0;
      clear_logs();
      push_job(0, 16'd0, 16'd16, 32'h500, 8'h30);
      cycle();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_valid_%0d", i), req_valid, 1);
         check($sformatf("bp_fields_%0d", i), {req_addr, req_len, req_seq}, {32'h500, 4'd8, 8'h30});
         cycle();
      end
      check("bp_no_advance", n_hs, 0);
      check("bp_addr_held", req_addr, 32'h500);
`ifdef WLS_PERF_CNT_EN
      check("bp_stall_cnt", stall_cnt, 5);
`endif
      req_ready = 1'b1;
      repeat (12) cycle();
      check("bp_hs_cnt", n_hs, 2);
      check("bp_hs1_addr", hs_addr[1], 32'h508);
      check("bp_done_seq", {n_jd[7:0], jd_seq[0]}, {8'd1, 8'h30});
`ifdef WLS_PERF_CNT_EN
      check("bp_stall_final", stall_cnt, 5);
`endif

      // Reset after the first handshake of a job.
      clear_logs();
      push_job(0, 16'd0, 16'd24, 32'h700, 8'h40);
      repeat (2) cycle();
      check("rst_first_hs", n_hs, 1);
      reset     = 1'b1;
      req_ready = 1'b0;
      cycle();
      reset     = 1'b0;
      req_ready = 1'b1;
      check_all_zero("rst_mid");
      check("rst_late_rsp_seen", rsp_done, 1);
      repeat (4) cycle();
      check("rst_no_done", n_jd, 0);
      check("rst_no_more_req", n_hs, 1);
      clear_logs();
      push_job(0, 16'd0, 16'd8, 32'h800, 8'h41);
      repeat (10) cycle();
      check("after_rst_pops", n_pop, 1);
      check("after_rst_hs", {n_hs[7:0], hs_addr[0], hs_len[0]}, {8'd1, 32'h800, 4'd8});
      check("after_rst_done", {n_jd[7:0], jd_seq[0]}, {8'd1, 8'h41});
      check("after_rst_lat", jd_cyc[0] - pop_cyc[0], 4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
